flash_id_poll: RTL and testbench

FLASH_ID_POLL -- requirements
Module: flash_id_poll

---
 rtl/flash_id_poll.sv | 156 +++++++++++++++
 tb/tb_flash_id_poll.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_id_poll.sv
// Reads the 3-byte JEDEC ID (opcode 9F) through a byte-level SPI engine,
// rejects all-zero / all-ones IDs with spaced retries, and times out a silent engine.
module flash_id_poll #(
  parameter int MAX_RETRY = 3,
  parameter int GAP_CYC   = 1000,
  parameter int TMO_CYC   = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        trans_req,
  output logic [7:0]  tx_dout,
  input  logic [7:0]  rx_din,
  input  logic        trans_done,
  output logic        cs_hold,
  output logic        busy,
  output logic [23:0] id_dout,
  output logic        id_vld,
  output logic        id_err
);

  localparam int CNT_MAX = (TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_RD0, S_RD1, S_RD2, S_CHK, S_GAP
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [3:0]        retry, retry_nxt;
  logic [23:0]       id_buf, id_buf_nxt;
  logic [23:0]       id_nxt;
  logic [7:0]        tx_nxt;
  logic              req_nxt, vld_nxt, err_nxt;
  logic              tmo_hit;

  // One counter serves both the per-byte timeout and the retry gap; it is
  // cleared whenever a byte request is issued or GAP is entered.
  assign tmo_hit = (cnt == CNT_W'(TMO_CYC - 1));

  assign cs_hold = (state == S_CMD) || (state == S_RD0) ||
                   (state == S_RD1) || (state == S_RD2);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      retry     <= '0;
      id_buf    <= '0;
      id_dout   <= '0;
      trans_req <= 1'b0;
      tx_dout   <= 8'h00;
      id_vld    <= 1'b0;
      id_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry     <= retry_nxt;
      id_buf    <= id_buf_nxt;
      id_dout   <= id_nxt;
      trans_req <= req_nxt;
      tx_dout   <= tx_nxt;
      id_vld    <= vld_nxt;
      id_err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    retry_nxt  = retry;
    id_buf_nxt = id_buf;
    id_nxt     = id_dout;
    tx_nxt     = tx_dout;
    req_nxt    = 1'b0;
    vld_nxt    = 1'b0;
    err_nxt    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CMD;
          req_nxt   = 1'b1;
          tx_nxt    = 8'h9F;
          cnt_nxt   = '0;
        end
      end

      S_CMD, S_RD0, S_RD1, S_RD2: begin
        // A done arriving on the last allowed cycle still wins over the timeout.
        if (trans_done) begin
          unique case (state)
            S_CMD:   state_nxt = S_RD0;
            S_RD0: begin
              state_nxt           = S_RD1;
              id_buf_nxt[23:16]   = rx_din;
            end
            S_RD1: begin
              state_nxt           = S_RD2;
              id_buf_nxt[15:8]    = rx_din;
            end
            default: begin
              state_nxt           = S_CHK;
              id_buf_nxt[7:0]     = rx_din;
            end
          endcase
          if (state != S_RD2) begin
            req_nxt = 1'b1;
            tx_nxt  = 8'hFF;
          end
          cnt_nxt = '0;
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
          retry_nxt = '0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_CHK: begin
        if ((id_buf != 24'h000000) && (id_buf != 24'hFFFFFF)) begin
          id_nxt    = id_buf;
          vld_nxt   = 1'b1;
          retry_nxt = '0;
          state_nxt = S_IDLE;
        end else if (int'(retry) < MAX_RETRY) begin
          retry_nxt = retry + 4'd1;
          cnt_nxt   = '0;
          state_nxt = S_GAP;
        end else begin
          err_nxt   = 1'b1;
          retry_nxt = '0;
          state_nxt = S_IDLE;
        end
      end

      S_GAP: begin
        if (cnt == CNT_W'(GAP_CYC - 1)) begin
          state_nxt = S_CMD;
          req_nxt   = 1'b1;
          tx_nxt    = 8'h9F;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_flash_id_poll.sv
// Scoreboard bench for flash_id_poll: a modelled SPI byte engine answers requests,
// expected tx bytes and ID results are queued and checked by an independent monitor.
module tb_flash_id_poll;

  localparam int MAX_RETRY = 3;
  localparam int GAP_CYC   = 5;
  localparam int TMO_CYC   = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        trans_req;
  logic [7:0]  tx_dout;
  logic [7:0]  rx_din;
  logic        trans_done;
  logic        cs_hold;
  logic        busy;
  logic [23:0] id_dout;
  logic        id_vld;
  logic        id_err;

  logic        eng_done = 1'b0;
  logic        spur_done = 1'b0;
  assign trans_done = eng_done | spur_done;

  flash_id_poll #(.MAX_RETRY(MAX_RETRY), .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .trans_req(trans_req), .tx_dout(tx_dout),
    .rx_din(rx_din), .trans_done(trans_done), .cs_hold(cs_hold), .busy(busy),
    .id_dout(id_dout), .id_vld(id_vld), .id_err(id_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic        is_tmo;
    logic [23:0] id;
  } res_t;

  logic [7:0] exp_tx[$];
  res_t       exp_res[$];
  logic [7:0] rx_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_seen = 0;
  int answer_left = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // SPI byte engine model: answers each request 8 cycles later
  initial begin
    int dly;
    logic pending;
    pending = 1'b0;
    dly = 0;
    rx_din = 8'h00;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (rst_n !== 1'b1) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (dly == 0) begin
            eng_done = 1'b1;
            rx_din   = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
            pending  = 1'b0;
          end else begin
            dly--;
          end
        end
        if (trans_req === 1'b1) begin
          if (pending) fail_event("req_while_pending");
          else if (answer_left != 0) begin
            pending = 1'b1;
            dly = 7;
            if (answer_left > 0) answer_left--;
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a request or a result
  initial begin
    int lowbusy;
    int last_req;
    res_t r;
    lowbusy = 0;
    last_req = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (trans_req === 1'b1) begin
          req_seen++;
          last_req = cyc;
          if (exp_tx.size() == 0) fail_event("unexpected_trans_req");
          else check("tx_dout", {24'd0, tx_dout}, {24'd0, exp_tx.pop_front()});
          check("cs_hold_at_req", {31'd0, cs_hold}, 32'd1);
          if (lowbusy > 0) check("gap_len", lowbusy, GAP_CYC + 1);
        end
        if (busy === 1'b1 && cs_hold === 1'b0) lowbusy++;
        else lowbusy = 0;
        if (id_vld === 1'b1 && id_err === 1'b1) fail_event("vld_and_err_together");
        if (id_vld === 1'b1 || id_err === 1'b1) begin
          if (exp_res.size() == 0) fail_event("unexpected_result");
          else begin
            r = exp_res.pop_front();
            check("result_kind", {30'd0, id_vld, id_err}, {30'd0, ~r.is_err, r.is_err});
            check("id_dout", {8'd0, id_dout}, {8'd0, r.id});
            check("cs_hold_at_result", {31'd0, cs_hold}, 32'd0);
            check("busy_at_result", {31'd0, busy}, 32'd0);
            if (r.is_tmo) check("tmo_latency", cyc - last_req, TMO_CYC);
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && exp_res.size() == 0 && busy === 1'b0) ok = 1'b1;
    end
    if (!ok) fail_event({name, "_timeout"});
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_req(input int target);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (req_seen >= target) ok = 1'b1;
    end
    if (!ok) fail_event("wait_req_timeout");
  endtask

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    rx_q.push_back(8'h00);
    rx_q.push_back(b0);
    rx_q.push_back(b1);
    rx_q.push_back(b2);
    exp_tx.push_back(8'h9F);
    exp_tx.push_back(8'hFF);
    exp_tx.push_back(8'hFF);
    exp_tx.push_back(8'hFF);
  endtask

  task automatic push_res(input logic is_err, input logic is_tmo, input logic [23:0] id);
    res_t r;
    r.is_err = is_err;
    r.is_tmo = is_tmo;
    r.id = id;
    exp_res.push_back(r);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_trans_req", {31'd0, trans_req}, 32'd0);
    check("rst_tx_dout", {24'd0, tx_dout}, 32'h00);
    check("rst_cs_hold", {31'd0, cs_hold}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_id_dout", {8'd0, id_dout}, 32'h0);
    check("rst_id_vld", {31'd0, id_vld}, 32'd0);
    check("rst_id_err", {31'd0, id_err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All-zero ID every time: MAX_RETRY+1 frames then one id_err, id_dout untouched
    for (int f = 0; f <= MAX_RETRY; f++) push_frame(8'h00, 8'h00, 8'h00);
    push_res(1'b1, 1'b0, 24'h000000);
    pulse_start();
    wait_done("retry_exhaust");

    // Normal read
    push_frame(8'hEF, 8'h40, 8'h18);
    push_res(1'b0, 1'b0, 24'hEF4018);
    pulse_start();
    wait_done("normal_read");

    // Two all-ones reads, then a good one
    push_frame(8'hFF, 8'hFF, 8'hFF);
    push_frame(8'hFF, 8'hFF, 8'hFF);
    push_frame(8'h20, 8'hBA, 8'h19);
    push_res(1'b0, 1'b0, 24'h20BA19);
    pulse_start();
    wait_done("retry_then_ok");

    // Spurious done in IDLE, then start pulsed again during RD1
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    check("spur_busy", {31'd0, busy}, 32'd0);
    check("spur_trans_req", {31'd0, trans_req}, 32'd0);
    push_frame(8'h9D, 8'h60, 8'h16);
    push_res(1'b0, 1'b0, 24'h9D6016);
    base = req_seen;
    pulse_start();
    wait_req(base + 3);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("start_in_rd1");

    // Engine answers the opcode byte then goes silent
    answer_left = 1;
    rx_q.push_back(8'h00);
    exp_tx.push_back(8'h9F);
    exp_tx.push_back(8'hFF);
    push_res(1'b1, 1'b1, 24'h9D6016);
    pulse_start();
    wait_done("timeout");
    answer_left = -1;
    rx_q.delete();

    // Reset during RD1, then a fresh frame
    push_frame(8'h11, 8'h22, 8'h33);
    exp_tx.pop_back();
    base = req_seen;
    pulse_start();
    wait_req(base + 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_cs_hold", {31'd0, cs_hold}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_id_dout", {8'd0, id_dout}, 32'h0);
    check("midrst_trans_req", {31'd0, trans_req}, 32'd0);
    repeat (2) @(negedge clk);
    rx_q.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_id_dout", {8'd0, id_dout}, 32'h0);
    push_frame(8'hEF, 8'h40, 8'h18);
    push_res(1'b0, 1'b0, 24'hEF4018);
    pulse_start();
    wait_done("after_reset");

    check("exp_tx_left", exp_tx.size(), 0);
    check("exp_res_left", exp_res.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
